// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative RV32M multiply/divide unit; stalls the core while busy.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] c_min_neg = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state;
    state_t             w_next_state;
    logic [CNTW-1:0]    r_cnt;
    logic [2:0]         r_funct3;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_result;

    logic               w_accept;
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_sign_a;
    logic               w_sign_b;
    logic               w_div_zero;
    logic               w_overflow;
    logic               w_fast;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_fast_result;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_sh;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_result;

    assign w_accept   = (r_state == S_IDLE) && start && !flush;
    assign w_signed_a = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_signed_b = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
    assign w_sign_a   = w_signed_a && op_a[WIDTH-1];
    assign w_sign_b   = w_signed_b && op_b[WIDTH-1];
    assign w_abs_a    = w_sign_a ? -op_a : op_a;
    assign w_abs_b    = w_sign_b ? -op_b : op_b;

    // Divide-by-zero and INT_MIN/-1 bypass the iteration entirely
    assign w_div_zero = funct3[2] && (op_b == '0);
    assign w_overflow = funct3[2] && !funct3[0] && (op_a == c_min_neg) && (op_b == '1);
    assign w_fast     = w_div_zero || w_overflow;
    assign w_fast_result = w_div_zero ? (funct3[1] ? op_a : '1)
                                      : (funct3[1] ? '0 : c_min_neg);

    // Multiply: add multiplicand into the upper half, shift the whole product right
    assign w_addend   = r_acc[0] ? r_opa : {WIDTH{1'b0}};
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts in quotient bits
    assign w_div_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_next = w_div_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_result = w_prod[WIDTH-1:0];
        case (r_funct3)
            3'd1, 3'd2, 3'd3: w_fix_result = w_prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       w_fix_result = w_quo;
            3'd6, 3'd7:       w_fix_result = w_rem;
            default:          w_fix_result = w_prod[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        stall        = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_accept;
                if (w_accept) begin
                    w_next_state = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                stall = 1'b1;
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                stall        = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                done         = !flush;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNTW'(WIDTH - 1);
            r_funct3 <= funct3;
            r_opa    <= w_abs_a;
            r_opb    <= w_abs_b;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_acc    <= funct3[2] ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
            if (w_fast) begin
                r_result <= w_fast_result;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNTW'(1);
            end
        end else if ((r_state == S_FIX) && !flush) begin
            r_result <= w_fix_result;
        end
    end

    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Self-checking bench for muldiv_unit (vector table + random ops).
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int LAT_NORM = 34;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[12];

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        p  = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Issue one instruction, hold start through DONE, check result, latency and stall length
    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit toggle);
        bit fast;
        int lat;
        int edges;
        int stalls;
        fast = f[2] && ((b == 32'd0) || (a == 32'h80000000 && b == 32'hFFFFFFFF && !f[0]));
        lat  = fast ? 1 : LAT_NORM;
        edges  = 0;
        stalls = 0;
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        #1;
        for (int i = 0; i < 100; i++) begin
            if (stall) stalls++;
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
            if (toggle) begin
                op_a = $urandom;
                op_b = $urandom;
            end
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        check({name, "_result"}, result, exp);
        check({name, "_latency"}, edges, lat);
        check({name, "_stalls"}, stalls, lat);
        check({name, "_stall_in_done"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_single_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        tbl[0]  = '{"mul",      3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        tbl[1]  = '{"mulh",     3'd1, 32'h80000000, 32'h80000000, 32'h40000000};
        tbl[2]  = '{"mulhu",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tbl[3]  = '{"mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
        tbl[4]  = '{"div",      3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        tbl[5]  = '{"rem",      3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        tbl[6]  = '{"divu",     3'd5, 32'd100,      32'd7,        32'd14};
        tbl[7]  = '{"remu",     3'd7, 32'd100,      32'd7,        32'd2};
        tbl[8]  = '{"divu_by0", 3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
        tbl[9]  = '{"rem_by0",  3'd6, 32'd5,        32'd0,        32'd5};
        tbl[10] = '{"div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        tbl[11] = '{"rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0};

        repeat (3) @(negedge clk);
        check("rst_stall",  {31'd0, stall}, 32'd0);
        check("rst_done",   {31'd0, done},  32'd0);
        check("rst_result", result,         32'd0);
        reset_n = 1'b1;

        // Consecutive entries also exercise back-to-back issue
        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].name, tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].exp, i[0]);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_no_second_op_stall", {31'd0, stall}, 32'd0);
            check("idle_no_second_op_done",  {31'd0, done},  32'd0);
        end

        // Flush in IDLE must block acceptance
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9;
        #1;
        check("flush_idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        #1;
        check("flush_idle_not_accepted", {31'd0, stall}, 32'd0);

        // Flush in CALC cycle 5
        do_op("mul_pre", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        #1;
        check("flush_calc_stall_before", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        #1;
        check("flush_calc_stall", {31'd0, stall}, 32'd0);
        check("flush_calc_done",  {31'd0, done},  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("flush_calc_no_done",   {31'd0, done}, 32'd0);
            check("flush_calc_result",    result,        32'd15);
        end
        do_op("mul_after_flush", 3'd0, 32'd6, 32'd7, 32'd42, 1'b0);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd1234; op_b = 32'd5678; start = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3;
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        check("arst_stall",  {31'd0, stall}, 32'd0);
        check("arst_done",   {31'd0, done},  32'd0);
        check("arst_result", result,         32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("arst_idle_stall", {31'd0, stall}, 32'd0);
        do_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0);

        // Randomised operations against the arithmetic reference
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            else if (sel == 3) b = -32'($urandom_range(1, 20));
            do_op("rand", f, a, b, ref_model(f, a, b), sel[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
